keypad_scan: RTL and testbench
==============================

# keypad_scan

Scanner for the 4x4 matrix keypad that produces the 4-bit key code consumed by the clock digit-setting logic. It drives one active-low column at a time, samples the active-low rows, and debounces both press and release. For each accepted press it emits one registered key code with a single-cycle valid strobe. It sits between the board keypad pins and the time-setting datapath.

## Interface
- SCAN_DIV, 50000: clk cycles per column dwell; one sample tick per dwell; minimum 2.
- DEBOUNCE, 4: consecutive agreeing sample ticks needed to accept a press or a release; minimum 1.
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- row_n  input  4  keypad rows, active-low (pulled up); already synchronized externally.
- col_n  output  4  column drive, active-low, exactly one bit low at all times.
- key_code  output  4  code of the last accepted key; held until the next acceptance.
- key_valid  output  1  one-cycle pulse when key_code is updated.
- key_held  output  1  high from acceptance until the release is accepted.

## Operation
- Key map (row r, column c): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D. Column c is driven by col_n[c] low; row r is read on row_n[r].
- Divider: counts 0..SCAN_DIV-1 and wraps. The sample tick is the cycle where count = SCAN_DIV-1. The divider runs continuously in all states.
- Row pick: lowest-indexed low bit of row_n. "Hit" means row_n != 4'hF.
- States are SCAN, DEBOUNCE and PRESSED. All transitions occur only on a tick.
  - SCAN, tick with no hit: rotate the column (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - SCAN, tick with a hit: latch the column and the picked row, set match count to 1, and go to DEBOUNCE. The column is frozen.
  - If DEBOUNCE = 1, acceptance happens at that same tick, and the machine goes straight to PRESSED.
  - DEBOUNCE, tick where the picked row equals the latched row: increment the match count. When the count reaches DEBOUNCE, accept and go to PRESSED.
  - DEBOUNCE, tick where the picked row differs or there is no hit: go to SCAN and rotate the column. No output changes.
  - Accept: key_code <= map(latched row, latched column), key_valid <= 1 for exactly one cycle, key_held <= 1.
  - PRESSED, tick where row_n[latched row] = 1: increment the release count. At DEBOUNCE, key_held <= 0, go to SCAN and rotate the column.
  - PRESSED, tick where row_n[latched row] = 0: clear the release count.
- Only one key is tracked at a time. Other keys pressed during DEBOUNCE or PRESSED are ignored. Auto-repeat is not supported.

## Timing
- Reset values: col_n = 4'b1110, key_code = 4'h0, key_valid = 0, key_held = 0, state SCAN, divider and all counts = 0.
- Reset takes priority over every other event, including a tick in the same cycle. Reset during PRESSED drops key_held on the next edge and does not generate a pulse.
- key_valid, key_code and key_held are registered. They change on the clock edge that ends the accepting tick cycle.
- Column changes are also registered on the tick edge. The first sample of a new column is therefore taken one full dwell later, which allows settling time.
- Press latency with a stable key: the key is detected on the first tick of its column, then DEBOUNCE-1 further ticks are needed. key_valid appears (DEBOUNCE-1)*SCAN_DIV cycles after the detect tick, plus 1 edge.
- Release latency: DEBOUNCE ticks with the row high.
- Counters saturate at DEBOUNCE. Their width is $clog2(DEBOUNCE+1).

## Test plan
- Reset and no key: after rst, col_n = 1110, key_code = 0, key_valid = 0, key_held = 0. With SCAN_DIV = 4, col_n steps 1101, 1011, 0111, 1110 every 4 cycles.
- Clean press: SCAN_DIV = 4, DEBOUNCE = 3, hold row 1 low whenever col_n[2] = 0. Expect col_n frozen at 1011, exactly one key_valid pulse with key_code = 6, and key_held = 1 for as long as the key is held.
- Bounce: the row goes low for only 2 ticks, then high (DEBOUNCE = 3). Expect no key_valid, key_code unchanged, and scanning to resume at col_n = 0111.
- Hold then release then re-press: hold for 20 ticks to get one pulse only. After release, key_held falls after 3 high ticks. A new press of r3 c0 gives a second pulse with key_code = 0.
- Two rows in one column: rows 0 and 2 both low on column 3. Expect key_code = A, the lower row winning.
- Reset mid-PRESSED: assert rst while key_held = 1. Next cycle, all outputs are at their reset values and col_n = 1110. The still-held key is then re-detected and produces a fresh pulse once debounced.

Source files
------------

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner: rotates one low column per dwell, debounces press and
// release on sample ticks, and emits a registered key code with a one-cycle valid strobe.
module keypad_scan #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [3:0]         col_q, col_d;
    logic [1:0]         row_q, row_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         code_q, code_d;
    logic               valid_q, valid_d;
    logic               held_q, held_d;

    logic               tick;
    logic               hit;
    logic [1:0]         pick_row;
    logic [1:0]         col_idx;
    logic [3:0]         col_rot;
    logic [CNT_W-1:0]   cnt_inc;
    logic               at_limit;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Lowest-indexed low row wins when several keys share the active column.
    always_comb begin
        hit = (row_n != 4'hF);
        if (!row_n[0])      pick_row = 2'd0;
        else if (!row_n[1]) pick_row = 2'd1;
        else if (!row_n[2]) pick_row = 2'd2;
        else                pick_row = 2'd3;

        case (col_q)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase

        tick     = (div_q == DIV_W'(SCAN_DIV - 1));
        col_rot  = {col_q[2:0], col_q[3]};
        cnt_inc  = cnt_q + CNT_W'(1);
        at_limit = (cnt_inc == CNT_W'(DEBOUNCE));
    end

    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (hit) begin
                        row_d = pick_row;
                        if (DEBOUNCE <= 1) begin
                            code_d  = key_map(pick_row, col_idx);
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_PRESSED;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_d = col_rot;
                    end
                end
                ST_DEBOUNCE: begin
                    if (hit && (pick_row == row_q)) begin
                        if (at_limit) begin
                            code_d  = key_map(row_q, col_idx);
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_PRESSED;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        col_d   = col_rot;
                        state_d = ST_SCAN;
                    end
                end
                ST_PRESSED: begin
                    // Only the latched row matters here; other keys are ignored.
                    if (row_n[row_q]) begin
                        if (at_limit) begin
                            held_d  = 1'b0;
                            cnt_d   = '0;
                            col_d   = col_rot;
                            state_d = ST_SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_SCAN;
            div_q   <= '0;
            col_q   <= 4'b1110;
            row_q   <= 2'd0;
            cnt_q   <= '0;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign col_n     = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench for keypad_scan: a keypad model drives rows from the scanned column,
// a scoreboard queue holds expected key codes and is drained on every key_valid pulse.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEBOUNCE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0] pressed [4];
    logic [3:0] exp_q [$];

    int checks    = 0;
    int errors    = 0;
    int pulse_cnt = 0;

    typedef struct {
        logic [1:0] row;
        logic [1:0] col;
        int         hold_ticks;
        logic [3:0] code;
    } press_vec_t;

    press_vec_t vecs [6];

    keypad_scan #(
        .SCAN_DIV(SCAN_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // A closed switch pulls its row low only while its column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_n[r] = ~|(pressed[r] & ~col_n);
        end
    end

    task automatic checkOutput(input string name, input logic [3:0] actual,
                               input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic wait_held(input logic level, input int budget, input string name);
        int n;
        n = 0;
        while (key_held !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (key_held !== level) begin
            errors++;
            $display("[TB] FAIL %s: key_held=%b after %0d cycles, expected %b", name, key_held, n, level);
        end
    endtask

    // Every pulse must match the oldest outstanding expected code.
    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: key_valid=1 code=%h, expected no pulse", key_code);
            end else begin
                checkOutput("pulse_code", key_code, exp_q.pop_front());
                checkOutput("held_at_pulse", {3'b000, key_held}, 4'h1);
            end
        end
    end

    task automatic applyStimulus(input press_vec_t v);
        int base;
        logic [1:0] next_col;
        base     = pulse_cnt;
        next_col = v.col + 2'd1;
        pressed[v.row][v.col] = 1'b1;
        exp_q.push_back(v.code);
        wait_held(1'b1, 200, "press_timeout");
        checkOutput("col_frozen", col_n, ~(4'b0001 << v.col));
        repeat (v.hold_ticks * SCAN_DIV) @(negedge clk);
        checkOutput("held_during_hold", {3'b000, key_held}, 4'h1);
        checkOutput("col_frozen_hold", col_n, ~(4'b0001 << v.col));
        checkOutput("single_pulse", 4'(pulse_cnt - base), 4'h1);
        pressed[v.row][v.col] = 1'b0;
        repeat ((DEBOUNCE - 1) * SCAN_DIV) @(negedge clk);
        checkOutput("held_before_release", {3'b000, key_held}, 4'h1);
        wait_held(1'b0, 2 * SCAN_DIV, "release_timeout");
        checkOutput("col_after_release", col_n, ~(4'b0001 << next_col));
        checkOutput("code_held", key_code, v.code);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int n;
        logic [1:0] ci;

        vecs[0] = '{row: 2'd1, col: 2'd2, hold_ticks: 20, code: 4'h6};
        vecs[1] = '{row: 2'd3, col: 2'd0, hold_ticks: 4,  code: 4'h0};
        vecs[2] = '{row: 2'd0, col: 2'd0, hold_ticks: 3,  code: 4'h1};
        vecs[3] = '{row: 2'd2, col: 2'd3, hold_ticks: 3,  code: 4'hC};
        vecs[4] = '{row: 2'd3, col: 2'd1, hold_ticks: 3,  code: 4'hF};
        vecs[5] = '{row: 2'd3, col: 2'd3, hold_ticks: 3,  code: 4'hD};

        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_col", col_n, 4'b1110);
        checkOutput("reset_code", key_code, 4'h0);
        checkOutput("reset_valid", {3'b000, key_valid}, 4'h0);
        checkOutput("reset_held", {3'b000, key_held}, 4'h0);
        rst = 1'b0;

        for (int k = 1; k <= 4 * SCAN_DIV; k++) begin
            @(negedge clk);
            ci = 2'((k / SCAN_DIV) % 4);
            checkOutput("idle_scan_col", col_n, ~(4'b0001 << ci));
        end

        for (int i = 0; i < $size(vecs); i++) begin
            applyStimulus(vecs[i]);
        end

        // Bounce: key seen on two ticks only, one short of acceptance.
        n = 0;
        while (col_n !== 4'b1011 && n < 64) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bounce_sync_col", col_n, 4'b1011);
        base = pulse_cnt;
        pressed[1][2] = 1'b1;
        repeat ((DEBOUNCE - 1) * SCAN_DIV) @(negedge clk);
        pressed[1][2] = 1'b0;
        repeat (SCAN_DIV - 1) @(negedge clk);
        checkOutput("bounce_col_frozen", col_n, 4'b1011);
        @(negedge clk);
        checkOutput("bounce_col_resume", col_n, 4'b0111);
        checkOutput("bounce_code_kept", key_code, 4'hD);
        checkOutput("bounce_no_held", {3'b000, key_held}, 4'h0);
        checkOutput("bounce_no_pulse", 4'(pulse_cnt - base), 4'h0);

        // Two rows on column 3: row 0 must win over row 2.
        pressed[0][3] = 1'b1;
        pressed[2][3] = 1'b1;
        exp_q.push_back(4'hA);
        wait_held(1'b1, 200, "two_rows_press_timeout");
        checkOutput("two_rows_code", key_code, 4'hA);
        checkOutput("two_rows_col", col_n, 4'b0111);
        pressed[0][3] = 1'b0;
        pressed[2][3] = 1'b0;
        wait_held(1'b0, (DEBOUNCE + 1) * SCAN_DIV, "two_rows_release_timeout");

        // Reset while a key is held, then re-detection of the same key.
        pressed[2][1] = 1'b1;
        exp_q.push_back(4'h8);
        wait_held(1'b1, 200, "rst_press_timeout");
        checkOutput("rst_pre_code", key_code, 4'h8);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_col", col_n, 4'b1110);
        checkOutput("rst_mid_code", key_code, 4'h0);
        checkOutput("rst_mid_valid", {3'b000, key_valid}, 4'h0);
        checkOutput("rst_mid_held", {3'b000, key_held}, 4'h0);
        rst = 1'b0;
        exp_q.push_back(4'h8);
        wait_held(1'b1, 200, "rst_redetect_timeout");
        checkOutput("rst_redetect_code", key_code, 4'h8);
        checkOutput("rst_redetect_col", col_n, 4'b1101);
        pressed[2][1] = 1'b0;
        wait_held(1'b0, (DEBOUNCE + 1) * SCAN_DIV, "rst_release_timeout");

        repeat (2 * SCAN_DIV) @(negedge clk);
        checkOutput("scoreboard_empty", 4'(exp_q.size()), 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
